beat_scheduler: RTL and testbench
=================================

BEAT_SCHEDULER -- requirements
Module: beat_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the note code width.
REQ-002 The block SHALL have parameter CNT_W, default 24, giving the beat counter width.
REQ-003 The block SHALL have parameter MIN_BEAT, default 4, giving the minimum beat length in cycles.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin scheduling.
REQ-007 stop  input  1  single-cycle request to halt scheduling.
REQ-008 beat_len  input  CNT_W  clock cycles per beat; latched on accepted start.
REQ-009 src0_valid / src1_valid  input  1  pattern source N has a note code available.
REQ-010 src0_data / src1_data  input  DATA_W  note code from source N.
REQ-011 src0_ready / src1_ready  output  1  note code from source N taken this cycle.
REQ-012 note_valid  output  1  note_data holds a scheduled note.
REQ-013 note_data  output  DATA_W  scheduled note code.
REQ-014 note_src  output  1  index of the source that supplied note_data.
REQ-015 note_ready  input  1  downstream accepts the note.
REQ-016 beat_tick  output  1  one-cycle pulse at each beat boundary.
REQ-017 running  output  1  high in every state except IDLE.
REQ-018 overrun  output  1  sticky flag: a beat expired while a note was still pending.

Function
REQ-019 The FSM SHALL have states IDLE, COUNT, GRANT and HOLD.
REQ-020 IDLE: on start with stop low, latch max(beat_len, MIN_BEAT), clear the counter and enter COUNT next cycle; start in any other state SHALL be ignored.
REQ-021 The counter SHALL increment every cycle outside IDLE, independent of the handshake; when it equals latched_len-1 it SHALL return to 0 and beat_tick SHALL pulse for exactly that cycle.
REQ-022 COUNT: on a beat_tick cycle the FSM SHALL go to GRANT.
REQ-023 GRANT (exactly one cycle) SHALL prefer the source not granted last (source 0 preferred after reset); if the preferred source is invalid and the other is valid, the other source SHALL be granted.
REQ-024 GRANT: srcN_ready SHALL be asserted combinationally only for the granted source whose srcN_valid is high; data and index SHALL be registered; the round-robin pointer SHALL update; the FSM SHALL go to HOLD with note_valid high next cycle.
REQ-025 GRANT with both sources invalid SHALL return to COUNT with no ready asserted and the pointer unchanged (empty beat).
REQ-026 HOLD: note_valid, note_data and note_src SHALL stay stable until note_valid&note_ready; note_valid SHALL deassert the following cycle and the FSM SHALL return to COUNT.
REQ-027 A beat_tick occurring in HOLD without the note accepted in the same cycle SHALL set overrun, that beat SHALL be dropped, and HOLD SHALL continue; acceptance on the tick cycle SHALL go directly to GRANT.
REQ-028 stop SHALL move any state to IDLE next cycle: the counter clears, note_valid drops (a pending note is abandoned) and no ready is asserted; stop SHALL win over a simultaneous start.
REQ-029 overrun SHALL clear only on reset or on an accepted start.

Reset
REQ-030 While resetn is low, the FSM SHALL be in IDLE, the counter and pointer cleared, and every output SHALL be 0, including note_data and overrun.
REQ-031 Reset asserted mid-operation SHALL abandon any pending note with no further handshake.

Configuration
REQ-032 With BEAT_SCHED_PAUSE_EN defined, the block SHALL add input pause: while pause is high and the block is not in IDLE, the counter SHALL freeze, beat_tick SHALL stay 0 and a HOLD handshake SHALL still complete.
REQ-033 Without BEAT_SCHED_PAUSE_EN, the block SHALL have no pause port and the counter SHALL never freeze.

Structure
REQ-034 Package beat_sched_pkg SHALL hold the state enum and the defaults for DATA_W, CNT_W and MIN_BEAT.
REQ-035 Sub-module beat_timer SHALL contain the counter, the length latch, the beat_tick generation and the pause freeze.

Verification
REQ-036 beat_len=10, start, both sources always valid -> beat_tick every 10 cycles; note_src alternates 0,1,0,...; note_ready held high.
REQ-037 beat_len=2 -> latched length 4; beat_tick every 4 cycles.
REQ-038 Only src1 valid with data 44 -> every note is 44, note_src=1, src0_ready never asserted.
REQ-039 note_ready held low for 25 cycles with beat_len=10 -> overrun=1, the note is unchanged, two beats are dropped, and release resumes scheduling.
REQ-040 stop issued in HOLD, start and stop in the same cycle, and resetn pulsed mid-COUNT -> IDLE, all outputs 0, no start taken.
REQ-041 With BEAT_SCHED_PAUSE_EN, pause held for 7 cycles mid-beat -> the next beat_tick is delayed by exactly 7 cycles.

Source files
------------

// File: rtl/beat_sched_pkg.sv
// Shared types and parameter defaults for the beat scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the FSM state encoding and the default widths and minimum beat
// length used by beat_scheduler and beat_timer.
package beat_sched_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int CNT_W_DEF    = 24;
  localparam int MIN_BEAT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_GRANT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/beat_timer.sv
// Beat timer: latches the beat length, counts cycles and flags each beat boundary.
// Latency: beat_tick is combinational from the counter; first tick len-1 cycles after load.
// Backpressure: none; the count never waits on any handshake, only on pause.
//
// Optional feature macro: BEAT_SCHED_PAUSE_EN (adds the pause input).
// Ports:
//   clk, resetn   clock and asynchronous active-low reset
//   load          accepted start: latch max(beat_len, MIN_BEAT) and clear the counter
//   clr           stop request: clear the counter
//   run           scheduler is outside IDLE, counter may advance
//   pause         (BEAT_SCHED_PAUSE_EN only) freeze the counter and suppress ticks
//   beat_len      requested cycles per beat
//   beat_tick     one-cycle pulse when the counter sits on its last value
module beat_timer
  import beat_sched_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MIN_BEAT = MIN_BEAT_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             clr,
  input  logic             run,
`ifdef BEAT_SCHED_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [CNT_W-1:0] beat_len,
  output logic             beat_tick
);

  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_q;
  logic             advance;
  logic             at_end;

`ifdef BEAT_SCHED_PAUSE_EN
  assign advance = run & ~pause;
`else
  assign advance = run;
`endif

  assign at_end    = (cnt_q == (len_q - CNT_W'(1)));
  // A frozen counter must not report a boundary, otherwise the FSM would
  // see the same beat once per paused cycle.
  assign beat_tick = advance & at_end;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_q <= CNT_W'(MIN_BEAT);
      cnt_q <= '0;
    end else begin
      if (load) begin
        // Very short beats would leave no room for grant + hold, so clamp.
        len_q <= (beat_len < CNT_W'(MIN_BEAT)) ? CNT_W'(MIN_BEAT) : beat_len;
      end

      if (load || clr) begin
        cnt_q <= '0;
      end else if (advance) begin
        cnt_q <= at_end ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/beat_scheduler.sv
// Beat scheduler: at every beat boundary grants one note from two pattern sources, round robin.
// Latency: grant cycle follows the beat tick; note_valid rises the cycle after the grant.
// Backpressure: note held until note_ready; a beat expiring while held is dropped and flags overrun.
//
// Optional feature macro: BEAT_SCHED_PAUSE_EN (adds input pause that freezes the beat counter).
// Ports:
//   clk, resetn                   clock and asynchronous active-low reset
//   pause                         (BEAT_SCHED_PAUSE_EN only) freeze the beat counter
//   start, stop                   single-cycle control requests; stop wins
//   beat_len                      cycles per beat, latched on an accepted start
//   srcN_valid/srcN_data          note code offered by pattern source N
//   srcN_ready                    note code taken from source N this cycle (combinational)
//   note_valid/note_data/note_src scheduled note and the source it came from
//   note_ready                    downstream accepts the note
//   beat_tick                     one-cycle pulse per beat boundary
//   running                       scheduler is outside IDLE
//   overrun                       sticky: a beat expired while a note was pending
module beat_scheduler
  import beat_sched_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MIN_BEAT = MIN_BEAT_DEF
) (
  input  logic              clk,
  input  logic              resetn,
`ifdef BEAT_SCHED_PAUSE_EN
  input  logic              pause,
`endif
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  beat_len,
  input  logic              src0_valid,
  input  logic [DATA_W-1:0] src0_data,
  output logic              src0_ready,
  input  logic              src1_valid,
  input  logic [DATA_W-1:0] src1_data,
  output logic              src1_ready,
  output logic              note_valid,
  output logic [DATA_W-1:0] note_data,
  output logic              note_src,
  input  logic              note_ready,
  output logic              beat_tick,
  output logic              running,
  output logic              overrun
);

  state_t state;
  logic   ptr;          // source preferred at the next grant
  logic   load;
  logic   [1:0] src_valid;
  logic   pick;
  logic   pick_ok;
  logic   do_grant;
  logic   accept;

  assign src_valid = {src1_valid, src0_valid};

  // Preferred source first, otherwise fall back to the other one.
  assign pick    = src_valid[ptr] ? ptr : ~ptr;
  assign pick_ok = |src_valid;

  // A stop in the grant cycle abandons the grant: nothing is taken.
  assign do_grant   = (state == ST_GRANT) & ~stop & pick_ok;
  assign src0_ready = do_grant & (pick == 1'b0);
  assign src1_ready = do_grant & (pick == 1'b1);

  assign accept  = note_valid & note_ready;
  assign load    = (state == ST_IDLE) & start & ~stop;
  assign running = (state != ST_IDLE);

  beat_timer #(
    .CNT_W    (CNT_W),
    .MIN_BEAT (MIN_BEAT)
  ) u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load),
    .clr       (stop),
    .run       (running),
`ifdef BEAT_SCHED_PAUSE_EN
    .pause     (pause),
`endif
    .beat_len  (beat_len),
    .beat_tick (beat_tick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      ptr        <= 1'b0;
      note_valid <= 1'b0;
      note_data  <= '0;
      note_src   <= 1'b0;
      overrun    <= 1'b0;
    end else if (stop) begin
      // Any pending note is abandoned; overrun stays sticky until next start.
      state      <= ST_IDLE;
      note_valid <= 1'b0;
      note_data  <= '0;
      note_src   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_COUNT;
            overrun <= 1'b0;
          end
        end

        ST_COUNT: begin
          if (beat_tick) state <= ST_GRANT;
        end

        ST_GRANT: begin
          if (pick_ok) begin
            note_valid <= 1'b1;
            note_data  <= pick ? src1_data : src0_data;
            note_src   <= pick;
            ptr        <= ~pick;
            state      <= ST_HOLD;
          end else begin
            // Empty beat: no source had a note, pointer stays put.
            state <= ST_COUNT;
          end
        end

        ST_HOLD: begin
          if (accept) begin
            note_valid <= 1'b0;
            // Accepting on a boundary lets that beat be granted straight away.
            state      <= beat_tick ? ST_GRANT : ST_COUNT;
          end else if (beat_tick) begin
            // The beat is lost; keep holding the old note.
            overrun <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beat_scheduler.sv
// Testbench for beat_scheduler: directed vectors, corner-case sequences and random traffic.
// Latency: n/a.
// Backpressure: note_ready driven by the stimulus.
module tb_beat_scheduler;
  import beat_sched_pkg::*;

  localparam int DW = 8;
  localparam int CW = 24;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;
  logic [CW-1:0] beat_len = '0;
  logic          src0_valid = 1'b0;
  logic          src1_valid = 1'b0;
  logic [DW-1:0] src0_data = '0;
  logic [DW-1:0] src1_data = '0;
  logic          note_ready = 1'b0;
  logic          src0_ready, src1_ready, note_valid, note_src, beat_tick, running, overrun;
  logic [DW-1:0] note_data;

  beat_scheduler #(.DATA_W(DW), .CNT_W(CW), .MIN_BEAT(MB)) dut (
    .clk        (clk),
    .resetn     (resetn),
`ifdef BEAT_SCHED_PAUSE_EN
    .pause      (pause),
`endif
    .start      (start),
    .stop       (stop),
    .beat_len   (beat_len),
    .src0_valid (src0_valid),
    .src0_data  (src0_data),
    .src0_ready (src0_ready),
    .src1_valid (src1_valid),
    .src1_data  (src1_data),
    .src1_ready (src1_ready),
    .note_valid (note_valid),
    .note_data  (note_data),
    .note_src   (note_src),
    .note_ready (note_ready),
    .beat_tick  (beat_tick),
    .running    (running),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Beat position is "cycles since start, modulo the clamped length",
  // with paused cycles not counted. A grant opportunity exists in the cycle
  // after a usable boundary; one note may be outstanding at a time.
  bit         m_run, m_grant, m_pend, m_src, m_pref, m_over;
  int         m_len, m_phase;
  logic [7:0] m_data;

  always @(negedge clk) begin
    bit exp_tick, g_ok, g, nxt_grant;
    #1;
    if (!resetn) begin
      check("rst_running", running, 0);
      check("rst_tick", beat_tick, 0);
      check("rst_note_valid", note_valid, 0);
      check("rst_note_data", note_data, 0);
      check("rst_note_src", note_src, 0);
      check("rst_src0_ready", src0_ready, 0);
      check("rst_src1_ready", src1_ready, 0);
      check("rst_overrun", overrun, 0);
      m_run = 0; m_grant = 0; m_pend = 0; m_src = 0; m_pref = 0; m_over = 0;
      m_len = MB; m_phase = 0; m_data = 0;
    end else begin
      exp_tick = m_run && (m_phase == m_len - 1) && !pause;
      g_ok = 0; g = 0;
      if (m_grant && !stop) begin
        if (m_pref ? src1_valid : src0_valid) begin g_ok = 1; g = m_pref; end
        else if (m_pref ? src0_valid : src1_valid) begin g_ok = 1; g = !m_pref; end
      end
      check("mdl_tick", beat_tick, exp_tick);
      check("mdl_running", running, m_run);
      check("mdl_note_valid", note_valid, m_pend);
      check("mdl_overrun", overrun, m_over);
      check("mdl_src0_ready", src0_ready, g_ok && !g);
      check("mdl_src1_ready", src1_ready, g_ok && g);
      if (m_pend || !m_run) begin
        check("mdl_note_data", note_data, m_pend ? m_data : 8'd0);
        check("mdl_note_src", note_src, m_pend ? m_src : 1'b0);
      end
      // state for the coming edge
      if (stop) begin
        m_run = 0; m_phase = 0; m_grant = 0; m_pend = 0; m_data = 0; m_src = 0;
      end else if (!m_run) begin
        if (start) begin
          m_run = 1; m_phase = 0; m_over = 0; m_grant = 0;
          m_len = (beat_len < MB) ? MB : int'(beat_len);
        end
      end else begin
        nxt_grant = 0;
        if (m_grant) begin
          if (g_ok) begin
            m_pend = 1; m_data = g ? src1_data : src0_data; m_src = g; m_pref = !g;
          end
        end else if (m_pend) begin
          if (note_ready) begin m_pend = 0; nxt_grant = exp_tick; end
          else if (exp_tick) m_over = 1;
        end else begin
          nxt_grant = exp_tick;
        end
        m_grant = nxt_grant;
        if (!pause) m_phase = (m_phase + 1) % m_len;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 0; start = 0; stop = 0; pause = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic do_start(input int len);
    @(negedge clk);
    beat_len = CW'(len); start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop = 1;
    @(negedge clk);
    stop = 0;
  endtask

  // Advance until beat_tick is seen; n = cycles advanced.
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk); #2; n++;
    end while (!beat_tick && n < budget);
    check("tick_seen", beat_tick, 1);
  endtask

  task automatic wait_valid(input logic want, input int budget);
    int n = 0;
    #2;
    while (note_valid !== want && n < budget) begin
      @(negedge clk); #2; n++;
    end
    check("note_valid_wait", note_valid, want);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_running"}, running, 0);
    check({tag, "_note_valid"}, note_valid, 0);
    check({tag, "_note_data"}, note_data, 0);
    check({tag, "_note_src"}, note_src, 0);
    check({tag, "_ready"}, {src1_ready, src0_ready}, 0);
    check({tag, "_tick"}, beat_tick, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  typedef struct { int len; int first; int period; } vec_t;

  initial begin
    vec_t vecs[7];
    int   n, cnt, s0cnt;
    logic [DW-1:0] held_d;
    logic held_s;
    logic [1:0] seen_src[4];

    vecs[0] = '{10, 9, 10};
    vecs[1] = '{2, 3, 4};
    vecs[2] = '{0, 3, 4};
    vecs[3] = '{3, 3, 4};
    vecs[4] = '{4, 3, 4};
    vecs[5] = '{5, 4, 5};
    vecs[6] = '{13, 12, 13};

    do_reset();
    #2; check_all_zero("after_reset");

    // beat length table, sources idle so every beat is empty
    for (int i = 0; i < 7; i++) begin
      do_stop();
      do_start(vecs[i].len);
      wait_tick(40, n); check($sformatf("first_tick_len%0d", vecs[i].len), n, vecs[i].first);
      wait_tick(40, n); check($sformatf("period_len%0d", vecs[i].len), n, vecs[i].period);
      wait_tick(40, n); check($sformatf("period2_len%0d", vecs[i].len), n, vecs[i].period);
    end

    // alternating grants with both sources always valid
    do_reset();
    src0_valid = 1; src1_valid = 1; src0_data = 8'h10; src1_data = 8'h21; note_ready = 1;
    do_start(10);
    cnt = 0;
    for (int c = 0; c < 80 && cnt < 4; c++) begin
      @(negedge clk); #2;
      if (note_valid && note_ready) begin seen_src[cnt] = {1'b0, note_src}; cnt++; end
    end
    check("alt_count", cnt, 4);
    check("alt_src0", seen_src[0], 0);
    check("alt_src1", seen_src[1], 1);
    check("alt_src2", seen_src[2], 0);
    check("alt_src3", seen_src[3], 1);

    // only source 1 has notes
    do_reset();
    src0_valid = 0; src0_data = 8'h5a; src1_valid = 1; src1_data = 8'd44; note_ready = 1;
    do_start(6);
    cnt = 0; s0cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #2;
      if (src0_ready) s0cnt++;
      if (note_valid) begin
        cnt++;
        check("src1_only_data", note_data, 44);
        check("src1_only_src", note_src, 1);
      end
    end
    check("src1_only_notes", cnt >= 3, 1);
    check("src1_only_src0_ready", s0cnt, 0);

    // downstream stall: two beats dropped, note held, overrun set
    do_reset();
    src0_valid = 1; src1_valid = 1; src0_data = 8'h11; src1_data = 8'h22; note_ready = 0;
    do_start(10);
    wait_valid(1, 30);
    held_d = note_data; held_s = note_src;
    check("stall_first_src", held_s, 0);
    check("stall_first_data", held_d, 8'h11);
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      if (beat_tick) cnt++;
      if (c < 24) begin @(negedge clk); #2; end
    end
    check("stall_dropped", cnt, 2);
    check("stall_overrun", overrun, 1);
    check("stall_hold_valid", note_valid, 1);
    check("stall_hold_data", note_data, 8'h11);
    check("stall_hold_src", note_src, 0);
    @(negedge clk); note_ready = 1;
    @(negedge clk);
    wait_valid(0, 5);
    wait_valid(1, 20);
    check("stall_resume_src", note_src, 1);
    check("stall_resume_data", note_data, 8'h22);
    check("stall_overrun_sticky", overrun, 1);

    // stop in HOLD
    do_reset();
    note_ready = 0;
    do_start(10);
    wait_valid(1, 30);
    cyc(2);
    do_stop();
    #2; check_all_zero("stop_hold");
    // start and stop together
    @(negedge clk); start = 1; stop = 1;
    @(negedge clk); start = 0; stop = 0;
    #2; check_all_zero("start_stop");
    cyc(3); #2; check("start_stop_later_running", running, 0);
    // reset mid-COUNT
    do_start(10);
    cyc(4);
    @(negedge clk); resetn = 0;
    #2; check_all_zero("reset_mid");
    @(negedge clk); resetn = 1;
    cyc(3); #2; check_all_zero("reset_after");

`ifdef BEAT_SCHED_PAUSE_EN
    // pause mid-beat delays the next boundary by the paused cycles
    do_reset();
    src0_valid = 0; src1_valid = 0;
    do_start(10);
    wait_tick(40, n);
    cyc(3);
    pause = 1;
    cyc(7);
    pause = 0;
    wait_tick(40, n);
    check("pause_delay", n, 7);
`endif

    // random traffic against the model
    do_reset();
    do_start(5);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      start = ($urandom % 12) == 0;
      stop = ($urandom % 60) == 0;
      beat_len = CW'($urandom_range(0, 9));
      src0_valid = ($urandom % 3) != 0;
      src1_valid = ($urandom % 3) != 0;
      src0_data = DW'($urandom);
      src1_data = DW'($urandom);
      note_ready = ($urandom % 4) != 0;
`ifdef BEAT_SCHED_PAUSE_EN
      pause = ($urandom % 8) == 0;
`endif
    end
    @(negedge clk);
    start = 0; stop = 0; pause = 0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
